// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_pkg
// Description : Shared definitions for the sequential ALU: operation codes,
//               FSM state encoding and single/multi-cycle classification.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

    // Single-cycle arithmetic / logic codes
    localparam logic [4:0] c_FUNC_ADD  = 5'b00000;
    localparam logic [4:0] c_FUNC_SUB  = 5'b00001;
    localparam logic [4:0] c_FUNC_AND  = 5'b00100;
    localparam logic [4:0] c_FUNC_OR   = 5'b00101;
    localparam logic [4:0] c_FUNC_XOR  = 5'b00110;
    localparam logic [4:0] c_FUNC_NAND = 5'b01100;
    localparam logic [4:0] c_FUNC_NOR  = 5'b01101;
    localparam logic [4:0] c_FUNC_XNOR = 5'b01110;
    localparam logic [4:0] c_FUNC_MVHI = 5'b01011;

    // Multi-cycle codes
    localparam logic [4:0] c_FUNC_MUL  = 5'b00010;
    localparam logic [4:0] c_FUNC_DIVU = 5'b00011;
    localparam logic [4:0] c_FUNC_REMU = 5'b00111;

    // Compare codes: bit 4 marks a compare, bit 3 inverts the outcome,
    // bit 2 selects zero as the B operand, bits 1:0 pick F/EQ/LT/LTE.
    localparam logic [4:0] c_CMP_F    = 5'b10000;
    localparam logic [4:0] c_CMP_EQ   = 5'b10001;
    localparam logic [4:0] c_CMP_LT   = 5'b10010;
    localparam logic [4:0] c_CMP_LTE  = 5'b10011;
    localparam logic [4:0] c_CMP_T    = 5'b11000;
    localparam logic [4:0] c_CMP_NE   = 5'b11001;
    localparam logic [4:0] c_CMP_GTE  = 5'b11010;
    localparam logic [4:0] c_CMP_GT   = 5'b11011;
    localparam logic [4:0] c_CMP_EQZ  = 5'b10101;
    localparam logic [4:0] c_CMP_LTZ  = 5'b10110;
    localparam logic [4:0] c_CMP_LTEZ = 5'b10111;
    localparam logic [4:0] c_CMP_NEZ  = 5'b11101;
    localparam logic [4:0] c_CMP_GTEZ = 5'b11110;
    localparam logic [4:0] c_CMP_GTZ  = 5'b11111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Codes that run through the iterative datapath
    function automatic logic isMultiCycle(input logic [4:0] f);
        return (f == c_FUNC_MUL) || (f == c_FUNC_DIVU) || (f == c_FUNC_REMU);
    endfunction

    // The zero-form patterns with bits 1:0 = 00 (10100, 11100) are not
    // defined compares and must behave as unlisted codes.
    function automatic logic isDefinedCompare(input logic [4:0] f);
        return f[4] && !(f[2] && (f[1:0] == 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_comb.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb
// Description : Combinational single-cycle ALU: add/sub, bitwise logic,
//               MVHI and all compare codes.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb
    import seq_alu_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter bit SIGNED_CMP = 1'b1
) (
    input  logic [4:0]           i_func,
    input  logic [BIT_WIDTH-1:0] i_opA,
    input  logic [BIT_WIDTH-1:0] i_opB,
    output logic [BIT_WIDTH-1:0] o_result,
    output logic                 o_compTrue
);

    localparam logic [BIT_WIDTH-1:0] c_HI_MASK = {BIT_WIDTH{1'b1}} << (BIT_WIDTH / 2);

    logic [BIT_WIDTH-1:0] w_rhs;
    logic                 w_eq;
    logic                 w_lt;
    logic                 w_base;

    // Against-zero forms substitute zero for operand B
    assign w_rhs = i_func[2] ? '0 : i_opB;
    assign w_eq  = (i_opA == w_rhs);

    generate
        if (SIGNED_CMP) begin : g_signedCmp
            assign w_lt = ($signed(i_opA) < $signed(w_rhs));
        end else begin : g_unsignedCmp
            assign w_lt = (i_opA < w_rhs);
        end
    endgenerate

    // Base relation before the bit-3 inversion
    always_comb begin
        w_base = 1'b0;
        case (i_func[1:0])
            2'b00:   w_base = 1'b0;
            2'b01:   w_base = w_eq;
            2'b10:   w_base = w_lt;
            default: w_base = w_lt | w_eq;
        endcase
    end

    // Result selection; unlisted codes fall through to zero
    always_comb begin
        o_result   = '0;
        o_compTrue = 1'b0;
        if (i_func[4]) begin
            o_compTrue = isDefinedCompare(i_func) & (w_base ^ i_func[3]);
            o_result   = {{(BIT_WIDTH-1){1'b0}}, o_compTrue};
        end else begin
            case (i_func)
                c_FUNC_ADD:  o_result = i_opA + i_opB;
                c_FUNC_SUB:  o_result = i_opA - i_opB;
                c_FUNC_AND:  o_result = i_opA & i_opB;
                c_FUNC_OR:   o_result = i_opA | i_opB;
                c_FUNC_XOR:  o_result = i_opA ^ i_opB;
                c_FUNC_NAND: o_result = ~(i_opA & i_opB);
                c_FUNC_NOR:  o_result = ~(i_opA | i_opB);
                c_FUNC_XNOR: o_result = ~(i_opA ^ i_opB);
                c_FUNC_MVHI: o_result = i_opB & c_HI_MASK;
                default:     o_result = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Sequential ALU with valid/ready handshake. Single-cycle ops
//               complete through alu_comb; MUL/DIVU/REMU iterate BIT_WIDTH
//               times through a shift-add / restoring-division datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter bit SIGNED_CMP = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           func,
    input  logic [BIT_WIDTH-1:0] data_in1,
    input  logic [BIT_WIDTH-1:0] data_in2,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] data_out,
    output logic                 comp_true,
    output logic                 div_zero
);

    localparam int             c_CW   = $clog2(BIT_WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(BIT_WIDTH - 1);

    state_t               r_state;
    logic [4:0]           r_func;
    logic [BIT_WIDTH-1:0] r_opA;    // MUL: multiplicand; DIV: dividend shifting into quotient
    logic [BIT_WIDTH-1:0] r_opB;    // MUL: multiplier;   DIV: divisor
    logic [BIT_WIDTH-1:0] r_acc;    // MUL: product;      DIV: partial remainder
    logic [c_CW-1:0]      r_iter;

    logic [BIT_WIDTH-1:0] w_aluResult;
    logic                 w_aluComp;
    logic                 w_isMul;
    logic [BIT_WIDTH-1:0] w_mulAcc;
    logic [BIT_WIDTH:0]   w_divDiff;
    logic [BIT_WIDTH-1:0] w_divShiftLow;
    logic                 w_divFits;
    logic [BIT_WIDTH-1:0] w_remNext;
    logic [BIT_WIDTH-1:0] w_quoNext;
    logic [BIT_WIDTH-1:0] w_mcResult;

    alu_comb #(
        .BIT_WIDTH  (BIT_WIDTH),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_aluComb (
        .i_func     (func),
        .i_opA      (data_in1),
        .i_opB      (data_in2),
        .o_result   (w_aluResult),
        .o_compTrue (w_aluComp)
    );

    assign in_ready = (r_state == ST_IDLE);
    assign w_isMul  = (r_func == c_FUNC_MUL);

    // One iteration of shift-add multiply and restoring division.
    // A zero divisor always "fits", yielding an all-ones quotient and
    // leaving the dividend as remainder without special casing.
    assign w_mulAcc      = r_acc + (r_opB[0] ? r_opA : '0);
    assign w_divDiff     = {r_acc, r_opA[BIT_WIDTH-1]} - {1'b0, r_opB};
    assign w_divShiftLow = {r_acc[BIT_WIDTH-2:0], r_opA[BIT_WIDTH-1]};
    assign w_divFits     = ~w_divDiff[BIT_WIDTH];
    assign w_remNext     = w_divFits ? w_divDiff[BIT_WIDTH-1:0] : w_divShiftLow;
    assign w_quoNext     = {r_opA[BIT_WIDTH-2:0], w_divFits};
    assign w_mcResult    = w_isMul ? w_mulAcc :
                           ((r_func == c_FUNC_DIVU) ? w_quoNext : w_remNext);

    // Control FSM, operand capture, iterative datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_func    <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_acc     <= '0;
            r_iter    <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            comp_true <= 1'b0;
            div_zero  <= 1'b0;
        end else if (flush) begin
            r_state   <= ST_IDLE;
            r_iter    <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            comp_true <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_func <= func;
                        r_opA  <= data_in1;
                        r_opB  <= data_in2;
                        r_acc  <= '0;
                        r_iter <= '0;
                        if (isMultiCycle(func)) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_state   <= ST_DONE;
                            out_valid <= 1'b1;
                            data_out  <= w_aluResult;
                            comp_true <= w_aluComp;
                            div_zero  <= 1'b0;
                        end
                    end
                end
                ST_BUSY: begin
                    r_iter <= r_iter + c_CW'(1);
                    if (w_isMul) begin
                        r_acc <= w_mulAcc;
                        r_opA <= r_opA << 1;
                        r_opB <= r_opB >> 1;
                    end else begin
                        r_acc <= w_remNext;
                        r_opA <= w_quoNext;
                    end
                    if (r_iter == c_LAST) begin
                        r_state   <= ST_DONE;
                        out_valid <= 1'b1;
                        data_out  <= w_mcResult;
                        comp_true <= 1'b0;
                        div_zero  <= ~w_isMul & (r_opB == '0);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state   <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
